systolic_feed_ctrl: RTL and testbench

- Sequences one matrix tile through the systolic array input path: reads K row-vectors from the operand buffer and drives them into the skew register bank with its enable.
- Then flushes zeros until the last operand has crossed the skew stages and the array, and reports completion.
- Sits between the tile scheduler (start/done handshake) and the buffer SRAM, skew bank and PE array (accumulator clear).

---
 rtl/systolic_feed_if.sv | 32 +++
 rtl/systolic_feed_ctrl.sv | 143 ++++++++++++++
 tb/tb_systolic_feed_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/systolic_feed_if.sv
// Handshake and datapath bundle between the tile scheduler/buffer side and the feed controller.
interface systolic_feed_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 16,
    parameter int unsigned K_WIDTH    = 10,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                    start;
    logic [K_WIDTH-1:0]      k_len;
    logic [ADDR_WIDTH-1:0]   base_addr;
    logic                    stall;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH*N-1:0] rd_data;
    logic [DATA_WIDTH*N-1:0] feed_data;
    logic                    skew_en;
    logic                    acc_clear;

    // Scheduler / buffer / array side
    modport master (
        output start, k_len, base_addr, stall, rd_data,
        input  busy, done, rd_en, rd_addr, feed_data, skew_en, acc_clear
    );

    // Feed controller side
    modport slave (
        input  start, k_len, base_addr, stall, rd_data,
        output busy, done, rd_en, rd_addr, feed_data, skew_en, acc_clear
    );
endinterface

// File: rtl/systolic_feed_ctrl.sv
// Sequences one tile of K row-vectors from the operand buffer into the skew bank,
// then flushes zeros through skew stages and array before signalling done.
module systolic_feed_ctrl #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned N          = 16,
    parameter int unsigned K_WIDTH    = 10,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    systolic_feed_if.slave bus
);
    localparam int unsigned VEC_W      = DATA_WIDTH * N;
    localparam int unsigned FLUSH_W    = (N > 1) ? $clog2(2 * N - 1) : 1;
    // Flush spans skew depth (N-1) plus array traversal (N-1)
    localparam int unsigned FLUSH_LAST = (N > 1) ? (2 * N - 3) : 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [K_WIDTH-1:0]    k_cnt_q, k_cnt_d;
    logic [K_WIDTH-1:0]    k_len_q, k_len_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;

    logic                  busy_c;
    logic                  done_c;
    logic                  rd_en_c;
    logic [ADDR_WIDTH-1:0] rd_addr_c;
    logic [VEC_W-1:0]      feed_data_c;
    logic                  skew_en_c;
    logic                  acc_clear_c;
    logic                  last_k;

    assign last_k = (k_cnt_q == (k_len_q - K_WIDTH'(1)));

    // State and tile-context registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_cnt_q     <= '0;
            k_len_q     <= '0;
            base_q      <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            k_cnt_q     <= k_cnt_d;
            k_len_q     <= k_len_d;
            base_q      <= base_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Next-state, counter updates and per-state outputs; stall freezes FEED/FLUSH
    always_comb begin
        state_d     = state_q;
        k_cnt_d     = k_cnt_q;
        k_len_d     = k_len_q;
        base_d      = base_q;
        flush_cnt_d = flush_cnt_q;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        rd_en_c     = 1'b0;
        rd_addr_c   = '0;
        feed_data_c = '0;
        skew_en_c   = 1'b0;
        acc_clear_c = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.k_len != '0) begin
                        state_d = CLEAR;
                        k_len_d = bus.k_len;
                        base_d  = bus.base_addr;
                        k_cnt_d = '0;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            CLEAR: begin
                busy_c      = 1'b1;
                acc_clear_c = 1'b1;
                rd_en_c     = 1'b1;
                rd_addr_c   = base_q;
                k_cnt_d     = '0;
                state_d     = FEED;
            end
            FEED: begin
                busy_c      = 1'b1;
                feed_data_c = bus.rd_data;
                if (!bus.stall) begin
                    skew_en_c = 1'b1;
                    if (!last_k) begin
                        rd_en_c   = 1'b1;
                        rd_addr_c = base_q + ADDR_WIDTH'(k_cnt_q) + ADDR_WIDTH'(1);
                        k_cnt_d   = k_cnt_q + K_WIDTH'(1);
                    end else if (N == 1) begin
                        state_d = DONE;
                    end else begin
                        state_d     = FLUSH;
                        flush_cnt_d = '0;
                    end
                end
            end
            FLUSH: begin
                busy_c = 1'b1;
                if (!bus.stall) begin
                    skew_en_c = 1'b1;
                    if (flush_cnt_q == FLUSH_W'(FLUSH_LAST)) begin
                        state_d = DONE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
                    end
                end
            end
            DONE: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy      = busy_c;
    assign bus.done      = done_c;
    assign bus.rd_en     = rd_en_c;
    assign bus.rd_addr   = rd_addr_c;
    assign bus.feed_data = feed_data_c;
    assign bus.skew_en   = skew_en_c;
    assign bus.acc_clear = acc_clear_c;

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Randomized and directed bench for systolic_feed_ctrl against a progress-count reference model.
module tb_systolic_feed_ctrl;
    localparam int unsigned DW    = 16;
    localparam int unsigned NL    = 4;
    localparam int unsigned KW    = 10;
    localparam int unsigned AW    = 10;
    localparam int unsigned VW    = DW * NL;
    localparam int unsigned DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    systolic_feed_if #(.DATA_WIDTH(DW), .N(NL), .K_WIDTH(KW), .ADDR_WIDTH(AW)) bus ();

    systolic_feed_ctrl #(.DATA_WIDTH(DW), .N(NL), .K_WIDTH(KW), .ADDR_WIDTH(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] mem [DEPTH];

    // Operand buffer: registered read, data held until the next strobe
    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: tile progress expressed as cycles since accept and advancing cycles
    bit m_known = 0;
    bit m_busy  = 0;
    bit m_zero  = 0;
    int m_k     = 0;
    int m_base  = 0;
    int m_rel   = 0;
    int m_adv   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic st, input logic [KW-1:0] kl, input logic [AW-1:0] ba,
                        input logic sl, input logic rs);
        logic          e_busy, e_done, e_rd, e_skew, e_clr;
        logic [AW-1:0] e_addr;
        logic [VW-1:0] e_feed;
        @(negedge clk);
        bus.start     = st;
        bus.k_len     = kl;
        bus.base_addr = ba;
        bus.stall     = sl;
        rst_n         = rs;
        #1;
        e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_skew = 1'b0; e_clr = 1'b0;
        e_addr = '0;   e_feed = '0;
        if (m_busy) begin
            e_busy = 1'b1;
            if (m_zero) begin
                e_done = 1'b1;
            end else if (m_rel == 1) begin
                e_clr  = 1'b1;
                e_rd   = 1'b1;
                e_addr = AW'(m_base);
            end else if (m_adv == m_k + 2 * NL - 2) begin
                e_done = 1'b1;
            end else begin
                e_skew = !sl;
                if (m_adv < m_k) e_feed = mem[(m_base + m_adv) % DEPTH];
                if (!sl && m_adv < m_k - 1) begin
                    e_rd   = 1'b1;
                    e_addr = AW'((m_base + m_adv + 1) % DEPTH);
                end
            end
        end
        if (m_known) begin
            check("busy",      64'(bus.busy),      64'(e_busy));
            check("done",      64'(bus.done),      64'(e_done));
            check("acc_clear", 64'(bus.acc_clear), 64'(e_clr));
            check("rd_en",     64'(bus.rd_en),     64'(e_rd));
            check("skew_en",   64'(bus.skew_en),   64'(e_skew));
            check("feed_data", 64'(bus.feed_data), 64'(e_feed));
            if (e_rd || !m_busy) check("rd_addr", 64'(bus.rd_addr), 64'(e_addr));
        end
        if (!rs) begin
            m_known = 1;
            m_busy  = 0;
        end else if (m_known) begin
            if (!m_busy) begin
                if (st) begin
                    m_busy = 1; m_zero = (kl == '0); m_k = int'(kl); m_base = int'(ba);
                    m_rel  = 1; m_adv  = 0;
                end
            end else if (e_done) begin
                m_busy = 0;
            end else begin
                if (m_rel >= 2 && !sl) m_adv++;
                m_rel++;
            end
        end
        cyc++;
    endtask

    task automatic run_tile(input int k, input int base, input logic [63:0] stall_m,
                            input logic [63:0] start_m, input int rst_at, input int ncyc);
        for (int c = 0; c < ncyc; c++) begin
            step((c == 0) ? 1'b1 : start_m[c], KW'(k), AW'(base), stall_m[c],
                 (c == rst_at) ? 1'b0 : 1'b1);
        end
    endtask

    initial begin
        logic [63:0] sm, stm;
        int          k, base, rst_at;
        bus.start = 1'b0; bus.k_len = '0; bus.base_addr = '0; bus.stall = 1'b0;
        bus.rd_data = '0;
        for (int i = 0; i < int'(DEPTH); i++) mem[i] = {$urandom, $urandom};

        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1);

        // Nominal tile, stall in FEED, stall in FLUSH
        run_tile(4, 'h010, 64'h0,   64'h0, -1, 14);
        run_tile(4, 'h010, 64'h38,  64'h0, -1, 17);
        run_tile(4, 'h010, 64'h300, 64'h0, -1, 16);
        // Empty tile
        run_tile(0, 'h055, 64'h0,   64'h0, -1, 4);
        // start during FEED and DONE, held into following IDLE
        run_tile(4, 'h020, 64'h0,   64'h3008, -1, 30);
        // Address wrap
        run_tile(4, 'h3FE, 64'h0,   64'h0, -1, 14);
        // Reset mid-FLUSH, then a fresh tile
        run_tile(4, 'h100, 64'h0,   64'h400, 8, 26);

        // Randomized tiles with stalls, stray starts and occasional reset
        for (int t = 0; t < 60; t++) begin
            k    = $urandom_range(0, 9);
            base = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 6, DEPTH - 1))
                                               : int'($urandom_range(0, DEPTH - 1));
            sm = '0; stm = '0;
            for (int b = 0; b < 64; b++) begin
                sm[b]  = ($urandom_range(0, 3) == 0);
                stm[b] = ($urandom_range(0, 9) == 0);
            end
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : -1;
            run_tile(k, base, sm, stm, rst_at, 40);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
